// File: rtl/timer_irq_scheduler.sv
// Four-channel programmable interval timer with a shared prescaler and a round-robin
// raise/acknowledge interrupt presenter, mapped into a 6-byte peripheral bus window.
module timer_irq_scheduler #(
    parameter logic [7:0]  BASE_ADDR      = 8'hF0,
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter int unsigned PRESCALE_MAX   = 49999
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA_IN,
    input  logic       BUS_WE,
    output logic [7:0] BUS_DATA_OUT,
    output logic       BUS_DATA_OE,
    output logic       IRQ_RAISE,
    output logic [1:0] IRQ_ID,
    input  logic       IRQ_ACK
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StRaise = 1'b1;
    localparam logic [PRESCALE_WIDTH-1:0] PrescMax = PRESCALE_WIDTH'(PRESCALE_MAX);
    localparam logic [PRESCALE_WIDTH-1:0] PrescOne = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      tick;
    logic [3:0]                ctrl_q, ctrl_d;
    logic [3:0][7:0]           period_q, period_d;
    logic [3:0][7:0]           count_q, count_d;
    logic [3:0]                pending_q, pending_d;
    logic [3:0]                expire;
    logic [3:0]                ack_clr;
    logic [0:0]                state_q, state_d;
    logic [1:0]                id_q, id_d;
    logic [1:0]                last_q, last_d;
    logic [1:0]                pick;
    logic [1:0]                cand;
    logic                      found;
    logic [7:0]                rdata_q, rdata_d;
    logic                      oe_q, oe_d;
    logic [7:0]                offset;
    logic [1:0]                widx;
    logic                      in_win, wr_en, rd_en;

    // Offset arithmetic wraps in 8 bits, so a single compare bounds the window.
    assign offset = BUS_ADDR - BASE_ADDR;
    assign in_win = offset < 8'd6;
    assign wr_en  = BUS_WE & in_win;
    assign rd_en  = ~BUS_WE & in_win;
    assign widx   = offset[1:0] - 2'd1;

    assign tick    = (presc_q == PrescMax);
    assign presc_d = tick ? '0 : presc_q + PrescOne;

    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        if (wr_en) begin
            if (offset == 8'd0) begin
                ctrl_d = BUS_DATA_IN[3:0];
            end else if (offset <= 8'd4) begin
                period_d[widx] = BUS_DATA_IN;
            end
        end
    end

    // A count at or above the period expires, so shrinking a period never wraps through 255.
    always_comb begin
        count_d = count_q;
        expire  = '0;
        for (int n = 0; n < 4; n++) begin
            if (!ctrl_q[n]) begin
                count_d[n] = '0;
            end else if (tick) begin
                if (count_q[n] >= period_q[n]) begin
                    count_d[n] = '0;
                    expire[n]  = 1'b1;
                end else begin
                    count_d[n] = count_q[n] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        pick  = last_q + 2'd1;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && pending_q[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        ack_clr = '0;
        case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    state_d = StRaise;
                    id_d    = pick;
                end
            end
            StRaise: begin
                if (IRQ_ACK) begin
                    state_d         = StIdle;
                    last_d          = id_q;
                    ack_clr[id_q]   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Expiry beats an ack-clear; a disabled channel can never hold a pending bit.
    assign pending_d = ((pending_q & ~ack_clr) | expire) & ctrl_q;

    always_comb begin
        rdata_d = '0;
        oe_d    = rd_en;
        if (rd_en) begin
            if (offset == 8'd0) begin
                rdata_d = {4'b0, ctrl_q};
            end else if (offset <= 8'd4) begin
                rdata_d = period_q[widx];
            end else begin
                rdata_d = {4'b0, pending_q};
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            presc_q   <= '0;
            ctrl_q    <= '0;
            period_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            state_q   <= StIdle;
            id_q      <= '0;
            last_q    <= 2'd3;
            rdata_q   <= '0;
            oe_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            ctrl_q    <= ctrl_d;
            period_q  <= period_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            id_q      <= id_d;
            last_q    <= last_d;
            rdata_q   <= rdata_d;
            oe_q      <= oe_d;
        end
    end

    assign IRQ_RAISE    = (state_q == StRaise);
    assign IRQ_ID       = id_q;
    assign BUS_DATA_OUT = rdata_q;
    assign BUS_DATA_OE  = oe_q;

endmodule

// File: tb/tb_timer_irq_scheduler.sv
// Scoreboard bench for timer_irq_scheduler: a behavioural model queues expected interrupt
// presentations and read data; a negedge monitor pops and compares what the DUT shows.
`timescale 1ns/1ps
module tb_timer_irq_scheduler;

    localparam logic [7:0] BASE = 8'hF0;
    localparam int PMAX = 3;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] BUS_ADDR = 8'h00;
    logic [7:0] BUS_DATA_IN = 8'h00;
    logic       BUS_WE = 1'b0;
    logic [7:0] BUS_DATA_OUT;
    logic       BUS_DATA_OE;
    logic       IRQ_RAISE;
    logic [1:0] IRQ_ID;
    logic       IRQ_ACK = 1'b0;

    timer_irq_scheduler #(
        .BASE_ADDR      (BASE),
        .PRESCALE_WIDTH (16),
        .PRESCALE_MAX   (PMAX)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .BUS_ADDR     (BUS_ADDR),
        .BUS_DATA_IN  (BUS_DATA_IN),
        .BUS_WE       (BUS_WE),
        .BUS_DATA_OUT (BUS_DATA_OUT),
        .BUS_DATA_OE  (BUS_DATA_OE),
        .IRQ_RAISE    (IRQ_RAISE),
        .IRQ_ID       (IRQ_ID),
        .IRQ_ACK      (IRQ_ACK)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    // Reference state, kept as plain integers.
    int       m_presc;
    bit [3:0] m_ctrl;
    int       m_period[4];
    int       m_count[4];
    bit [3:0] m_pend;
    bit       m_raised;
    int       m_id;
    int       m_last;
    bit       m_oe;

    int irq_q[$];
    int rd_q[$];
    int seen[$];

    bit         prev_raise = 1'b0;
    logic [1:0] prev_id = 2'd0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_ctrl = '0;
        for (int n = 0; n < 4; n++) begin
            m_period[n] = 0;
            m_count[n] = 0;
        end
        m_pend = '0;
        m_raised = 1'b0;
        m_id = 0;
        m_last = 3;
        m_oe = 1'b0;
        irq_q.delete();
        rd_q.delete();
    endtask

    function automatic int reg_val(input int off);
        if (off == 0) return int'(m_ctrl);
        if (off <= 4) return m_period[off-1];
        return int'(m_pend);
    endfunction

    // One clock of the register map, timers and presenter, from the rules as written.
    task automatic model_step();
        logic [7:0] off8;
        int off;
        bit in_win;
        bit tick;
        bit [3:0] exp_set;
        bit [3:0] np;
        off8 = BUS_ADDR - BASE;
        off = int'(off8);
        in_win = off < 6;
        m_oe = 1'b0;
        if (!BUS_WE && in_win) begin
            m_oe = 1'b1;
            rd_q.push_back(reg_val(off));
        end
        tick = (m_presc == PMAX);
        exp_set = '0;
        for (int n = 0; n < 4; n++) begin
            if (!m_ctrl[n]) m_count[n] = 0;
            else if (tick) begin
                if (m_count[n] >= m_period[n]) begin
                    m_count[n] = 0;
                    exp_set[n] = 1'b1;
                end else m_count[n] = m_count[n] + 1;
            end
        end
        np = m_pend;
        if (m_raised && IRQ_ACK) np[m_id] = 1'b0;
        np = (np | exp_set) & m_ctrl;
        if (m_raised) begin
            if (IRQ_ACK) begin
                m_raised = 1'b0;
                m_last = m_id;
            end
        end else if (m_pend != 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (!m_raised && m_pend[(m_last + k) % 4]) begin
                    m_id = (m_last + k) % 4;
                    m_raised = 1'b1;
                end
            end
            irq_q.push_back(m_id);
        end
        m_pend = np;
        if (BUS_WE && in_win) begin
            if (off == 0) m_ctrl = BUS_DATA_IN[3:0];
            else if (off <= 4) m_period[off-1] = int'(BUS_DATA_IN);
        end
        m_presc = tick ? 0 : m_presc + 1;
    endtask

    initial forever begin
        @(posedge CLK);
        cycle++;
        if (!Reset) model_step();
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    initial forever begin
        @(negedge CLK);
        if (Reset) begin
            prev_raise = 1'b0;
        end else begin
            check("irq_raise_level", int'(IRQ_RAISE), int'(m_raised));
            check("oe_level", int'(BUS_DATA_OE), int'(m_oe));
            if (IRQ_RAISE && !prev_raise) begin
                seen.push_back(int'(IRQ_ID));
                if (irq_q.size() == 0) check("irq_unexpected", 1, 0);
                else check("irq_id", int'(IRQ_ID), irq_q.pop_front());
            end else if (IRQ_RAISE && prev_raise) begin
                check("irq_id_stable", int'(IRQ_ID), int'(prev_id));
            end
            if (BUS_DATA_OE) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_data", int'(BUS_DATA_OUT), rd_q.pop_front());
            end else begin
                check("rd_idle_zero", int'(BUS_DATA_OUT), 0);
            end
            prev_raise = IRQ_RAISE;
            prev_id = IRQ_ID;
        end
    end

    task automatic bus_write(input int off, input int data);
        BUS_ADDR = BASE + 8'(off);
        BUS_DATA_IN = 8'(data);
        BUS_WE = 1'b1;
        @(negedge CLK);
        BUS_WE = 1'b0;
        BUS_ADDR = 8'h00;
    endtask

    task automatic bus_read(input int off);
        BUS_ADDR = BASE + 8'(off);
        BUS_WE = 1'b0;
        @(negedge CLK);
        BUS_ADDR = 8'h00;
    endtask

    task automatic ack();
        IRQ_ACK = 1'b1;
        @(negedge CLK);
        IRQ_ACK = 1'b0;
    endtask

    task automatic wait_raise(input int budget);
        int k = 0;
        while (!IRQ_RAISE && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (!IRQ_RAISE) check("raise_timeout", 0, 1);
    endtask

    // Called just after a negedge; asserts Reset asynchronously mid-cycle.
    task automatic do_reset();
        #2;
        Reset = 1'b1;
        BUS_WE = 1'b0;
        BUS_ADDR = 8'h00;
        BUS_DATA_IN = 8'h00;
        IRQ_ACK = 1'b0;
        #1;
        check("rst_raise", int'(IRQ_RAISE), 0);
        check("rst_oe", int'(BUS_DATA_OE), 0);
        check("rst_dout", int'(BUS_DATA_OUT), 0);
        check("rst_id", int'(IRQ_ID), 0);
        model_reset();
        prev_raise = 1'b0;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int exp_rr[5];
        int off;
        int r;
        exp_rr = '{0, 1, 2, 3, 0};
        model_reset();
        repeat (2) @(negedge CLK);
        do_reset();
        bus_read(0);
        bus_read(5);

        // Basic period: PERIOD0=2 expires every 3 ticks of 4 clocks.
        bus_write(1, 2);
        bus_write(0, 1);
        wait_raise(40);
        check("basic_id", int'(IRQ_ID), 0);
        c0 = cycle;
        for (int i = 0; i < 2; i++) begin
            ack();
            check("basic_ack_drop", int'(IRQ_RAISE), 0);
            bus_read(5);
            check("basic_pending_zero", int'(BUS_DATA_OUT), 0);
            wait_raise(40);
            c1 = cycle;
            check("basic_interval", c1 - c0, 12);
            c0 = c1;
        end

        // Round-robin with all channels at PERIOD=0.
        @(negedge CLK);
        do_reset();
        seen.delete();
        bus_write(0, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            wait_raise(40);
            repeat (3) @(negedge CLK);
            ack();
            check("rr_gap", int'(IRQ_RAISE), 0);
        end
        check("rr_count", (seen.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5 && i < seen.size(); i++) check("rr_order", seen[i], exp_rr[i]);

        // Bus access, including an address just past the window.
        do_reset();
        bus_write(3, 8'hA5);
        bus_write(0, 8'hFF);
        bus_read(3);
        check("bus_p2_oe", int'(BUS_DATA_OE), 1);
        check("bus_p2_data", int'(BUS_DATA_OUT), 8'hA5);
        bus_read(0);
        check("bus_ctrl_oe", int'(BUS_DATA_OE), 1);
        check("bus_ctrl_data", int'(BUS_DATA_OUT), 8'h0F);
        bus_read(6);
        check("bus_oob_oe", int'(BUS_DATA_OE), 0);

        // Ack on the same edge as a fresh channel-0 expiry.
        do_reset();
        bus_write(0, 1);
        wait_raise(20);
        for (int k = 0; k < 10 && m_presc != PMAX; k++) @(negedge CLK);
        ack();
        check("coll_low", int'(IRQ_RAISE), 0);
        bus_read(5);
        check("coll_pending", int'(BUS_DATA_OUT), 1);
        check("coll_reraise", int'(IRQ_RAISE), 1);
        check("coll_id", int'(IRQ_ID), 0);

        // Period shrink below the running count, then disable while raised.
        @(negedge CLK);
        do_reset();
        bus_write(2, 20);
        bus_write(0, 2);
        for (int k = 0; k < 200 && !(m_count[1] == 7 && m_presc != PMAX); k++) @(negedge CLK);
        check("shrink_count7", m_count[1], 7);
        bus_write(2, 3);
        wait_raise(PMAX + 3);
        check("shrink_id", int'(IRQ_ID), 1);
        bus_write(0, 0);
        @(negedge CLK);
        bus_read(5);
        check("disable_pending", int'(BUS_DATA_OUT), 0);
        repeat (3) @(negedge CLK);
        check("disable_hold", int'(IRQ_RAISE), 1);
        ack();
        repeat (3) @(negedge CLK);
        check("disable_after_ack", int'(IRQ_RAISE), 0);

        // Reset while raised and with read data on the bus.
        bus_write(0, 8'h0F);
        wait_raise(20);
        bus_read(5);
        do_reset();
        bus_read(5);
        check("post_rst_pending", int'(BUS_DATA_OUT), 0);
        bus_write(0, 8'h0F);
        wait_raise(20);
        check("post_rst_first_id", int'(IRQ_ID), 0);

        // Randomised traffic: register writes, reads, timely and stray acks.
        @(negedge CLK);
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                off = $urandom_range(0, 7);
                if (off >= 1 && off <= 4) bus_write(off, $urandom_range(0, 5));
                else bus_write(off, $urandom_range(0, 255));
            end else if (r < 16) begin
                bus_read($urandom_range(0, 7));
            end else if ((IRQ_RAISE && r < 45) || r < 18) begin
                ack();
            end else begin
                @(negedge CLK);
            end
        end

        repeat (2) @(negedge CLK);
        #1;
        check("queue_drain", irq_q.size() + rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
